// File: rtl/note_sequencer.sv
// note_sequencer: record/playback step sequencer for the keyboard music path.
// In REC it captures the live key code into a 2^DEPTH_LOG2-step note memory
// on every beat. In PLAY it replays the stored steps at the same beat rate.
// note_code feeds the key decoder and the PWM music generator. beat_num
// reports the current step to the VGA score display.
module note_sequencer #(
  parameter int DEPTH_LOG2 = 9,
  parameter int CODE_W     = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  beat,
  input  logic                  edit,
  input  logic                  play,
  input  logic [CODE_W-1:0]     key_code,
  output logic [CODE_W-1:0]     note_code,
  output logic [DEPTH_LOG2-1:0] beat_num,
  output logic [DEPTH_LOG2:0]   rec_len,
  output logic [1:0]            state,
  output logic                  start,
  output logic                  done
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REC  = 2'b01,
    PLAY = 2'b10
  } fsm_t;

  fsm_t                  fsm;
  logic                  beat_d;
  logic                  step;
  logic                  wr_en;
  logic                  last_step;
  logic                  addr_full;
  logic [DEPTH_LOG2-1:0] addr;
  logic [CODE_W-1:0]     mem [DEPTH];

  // One step per rising edge of the beat square wave.
  assign step      = beat & ~beat_d;
  // A step is written only while edit is still held; edit=0 wins over a step.
  assign wr_en     = (fsm == REC) && edit && step;
  // Playback ends when the step just finished is the last recorded one.
  assign last_step = (({1'b0, addr} + 1'b1) == rec_len);
  assign addr_full = (addr == {DEPTH_LOG2{1'b1}});

  assign beat_num  = addr;
  assign state     = fsm;

  // Delay beat by one clock for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values that were present before the edge.
    if (!reset) beat_d <= 1'b0;
    else        beat_d <= beat;
  end

  // Note memory: synchronous write of the live key on each recorded step.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset on purpose. Stored notes survive reset,
    // and a reset-free array maps onto block RAM instead of flops.
    if (wr_en) mem[addr] <= key_code;
  end

  // Sequencer FSM with registered outputs and registered memory read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm       <= IDLE;
      addr      <= '0;
      rec_len   <= '0;
      note_code <= '0;
      start     <= 1'b0;
      done      <= 1'b0;
    end else begin
      start <= 1'b0;
      done  <= 1'b0;
      case (fsm)
        IDLE: begin
          note_code <= key_code;
          if (edit) begin
            fsm     <= REC;
            addr    <= '0;
            rec_len <= '0;
          end else if (play && (rec_len != '0)) begin
            fsm   <= PLAY;
            addr  <= '0;
            start <= 1'b1;
          end
        end

        REC: begin
          note_code <= key_code;
          if (!edit) begin
            fsm <= IDLE;
          end else if (step) begin
            rec_len <= {1'b0, addr} + 1'b1;
            addr    <= addr + 1'b1;
            // Memory full: the write at the last address wraps and stops.
            if (addr_full) fsm <= IDLE;
          end
        end

        PLAY: begin
          if (!play || edit) begin
            // Abort takes priority over a simultaneous step; no done pulse.
            fsm       <= IDLE;
            addr      <= '0;
            note_code <= '0;
          end else if (step && last_step) begin
            fsm       <= IDLE;
            addr      <= '0;
            done      <= 1'b1;
            note_code <= '0;
          end else begin
            note_code <= mem[addr];
            if (step) addr <= addr + 1'b1;
          end
        end

        default: begin
          fsm       <= IDLE;
          addr      <= '0;
          note_code <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Testbench for note_sequencer. The reference model is the list of notes
// that a recording should hold. Playback expectations are read from that list.
module tb_note_sequencer;

  localparam int DL    = 9;
  localparam int CW    = 6;
  localparam int DEPTH = 512;
  localparam int LIVE  = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          beat = 1'b0;
  logic          edit = 1'b0;
  logic          play = 1'b0;
  logic [CW-1:0] key_code = '0;
  logic [CW-1:0] note_code;
  logic [DL-1:0] beat_num;
  logic [DL:0]   rec_len;
  logic [1:0]    state;
  logic          start;
  logic          done;

  int passed = 0;
  int total  = 0;

  int stim_q[$];
  int exp_q[$];

  note_sequencer #(.DEPTH_LOG2(DL), .CODE_W(CW)) dut (
    .clk      (clk),
    .reset    (reset),
    .beat     (beat),
    .edit     (edit),
    .play     (play),
    .key_code (key_code),
    .note_code(note_code),
    .beat_num (beat_num),
    .rec_len  (rec_len),
    .state    (state),
    .start    (start),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " state"},     32'(state),     32'd0);
    check({tag, " beat_num"},  32'(beat_num),  32'd0);
    check({tag, " rec_len"},   32'(rec_len),   32'd0);
    check({tag, " note_code"}, 32'(note_code), 32'd0);
    check({tag, " start"},     32'(start),     32'd0);
    check({tag, " done"},      32'(done),      32'd0);
  endtask

  // Record every code in stim_q. The expected recording becomes stim_q.
  task automatic record();
    int n;
    n = stim_q.size();
    edit = 1'b1;
    tick();
    check("rec entry state", 32'(state), 32'd1);
    check("rec entry rec_len", 32'(rec_len), 32'd0);
    check("rec entry beat_num", 32'(beat_num), 32'd0);
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      key_code = CW'(stim_q[i]);
      beat = 1'b1;
      tick();
      exp_q.push_back(stim_q[i]);
      if (i == DEPTH - 1) begin
        edit = 1'b0;
        check("rec full state", 32'(state), 32'd0);
        check("rec full rec_len", 32'(rec_len), 32'(DEPTH));
        check("rec full beat_num", 32'(beat_num), 32'd0);
      end else begin
        check("rec beat_num", 32'(beat_num), 32'(i + 1));
        check("rec rec_len", 32'(rec_len), 32'(i + 1));
      end
      beat = 1'b0;
      tick();
    end
    if (edit) begin
      edit = 1'b0;
      tick();
    end
    check("rec exit state", 32'(state), 32'd0);
    check("rec exit rec_len", 32'(rec_len), 32'(n));
  endtask

  // Play the full recording and compare every note against exp_q.
  task automatic play_back();
    int n;
    n = exp_q.size();
    key_code = CW'(LIVE);
    play = 1'b1;
    tick();
    check("play entry state", 32'(state), 32'd2);
    check("play entry start", 32'(start), 32'd1);
    check("play entry beat_num", 32'(beat_num), 32'd0);
    tick();
    check("play start width", 32'(start), 32'd0);
    check("play first note", 32'(note_code), 32'(exp_q[0]));
    for (int i = 0; i < n; i++) begin
      beat = 1'b1;
      tick();
      if (i == n - 1) begin
        play = 1'b0;
        check("play done pulse", 32'(done), 32'd1);
        check("play done state", 32'(state), 32'd0);
        check("play done beat_num", 32'(beat_num), 32'd0);
        check("play done note", 32'(note_code), 32'd0);
      end else begin
        check("play step done", 32'(done), 32'd0);
        check("play step beat_num", 32'(beat_num), 32'(i + 1));
        check("play step note hold", 32'(note_code), 32'(exp_q[i]));
      end
      beat = 1'b0;
      tick();
      if (i == n - 1) begin
        check("play done width", 32'(done), 32'd0);
        check("play live resume", 32'(note_code), 32'(LIVE));
        check("play after state", 32'(state), 32'd0);
      end else begin
        check("play note", 32'(note_code), 32'(exp_q[i + 1]));
      end
    end
  endtask

  initial begin
    // Reset values
    #2;
    check_reset_outputs("reset");
    tick();
    tick();
    reset = 1'b1;
    tick();
    check_reset_outputs("post reset");

    // Live passthrough in IDLE
    key_code = 6'd9;
    tick();
    check("idle passthrough", 32'(note_code), 32'd9);

    // Playback request with nothing recorded
    play = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("empty play state", 32'(state), 32'd0);
      check("empty play start", 32'(start), 32'd0);
      check("empty play done", 32'(done), 32'd0);
      check("empty play beat_num", 32'(beat_num), 32'd0);
    end
    play = 1'b0;

    // edit and play together: edit wins
    edit = 1'b1;
    play = 1'b1;
    tick();
    check("edit+play state", 32'(state), 32'd1);
    check("edit+play start", 32'(start), 32'd0);
    edit = 1'b0;
    play = 1'b0;
    tick();
    check("edit+play exit state", 32'(state), 32'd0);
    check("edit+play rec_len", 32'(rec_len), 32'd0);

    // Directed recording 3,7,0,12 and playback
    stim_q = '{3, 7, 0, 12};
    record();
    play_back();

    // Randomized recordings, each played back
    for (int r = 0; r < 4; r++) begin
      int n;
      n = int'($urandom_range(1, 24));
      stim_q.delete();
      for (int i = 0; i < n; i++) stim_q.push_back(int'($urandom_range(0, 63)));
      record();
      play_back();
    end

    // Abort playback at beat_num=2 together with a step
    stim_q.delete();
    for (int i = 0; i < 6; i++) stim_q.push_back(int'($urandom_range(1, 63)));
    record();
    play = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 2; i++) begin
      beat = 1'b1;
      tick();
      beat = 1'b0;
      tick();
    end
    check("abort pre beat_num", 32'(beat_num), 32'd2);
    check("abort pre note", 32'(note_code), 32'(exp_q[2]));
    play = 1'b0;
    beat = 1'b1;
    tick();
    check("abort state", 32'(state), 32'd0);
    check("abort beat_num", 32'(beat_num), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort note", 32'(note_code), 32'd0);
    beat = 1'b0;
    tick();
    check("abort after done", 32'(done), 32'd0);
    check("abort rec_len kept", 32'(rec_len), 32'd6);

    // Full memory: 512 steps with key_code = step mod 64
    stim_q.delete();
    for (int i = 0; i < DEPTH; i++) stim_q.push_back(i % 64);
    record();
    play_back();

    // Reset asserted mid-REC
    edit = 1'b1;
    tick();
    key_code = 6'd11;
    for (int i = 0; i < 2; i++) begin
      beat = 1'b1;
      tick();
      beat = 1'b0;
      tick();
    end
    check("mid rec beat_num", 32'(beat_num), 32'd2);
    reset = 1'b0;
    #1;
    check_reset_outputs("async reset");
    edit = 1'b0;
    tick();
    reset = 1'b1;
    tick();

    // rec_len was lost, so playback must not start
    play = 1'b1;
    tick();
    check("lost len state", 32'(state), 32'd0);
    check("lost len start", 32'(start), 32'd0);
    tick();
    check("lost len beat_num", 32'(beat_num), 32'd0);
    play = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
